// File: rtl/accel_dispatch.sv
// accel_dispatch: queues hash/encrypt/decrypt requests and runs them one at a time on their engines.
// Latency: request at edge N gives *_start in the cycle after edge N+2; *_done follows the matching *_fin by one cycle.
// Backpressure: wbhalt stalls the CPU while work is queued or in flight; a repeat request for a still-queued op is dropped and flagged.
module accel_dispatch #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        H_int,
  input  logic        E_int,
  input  logic        D_int,
  input  logic [10:0] offset,
  input  logic        H_fin,
  input  logic        E_fin,
  input  logic        D_fin,
  output logic        H_start,
  output logic        E_start,
  output logic        D_start,
  output logic [10:0] eng_offset,
  output logic        H_done,
  output logic        E_done,
  output logic        D_done,
  output logic        wbhalt,
  output logic        timeout_err,
  output logic        ovf_err
);

  // Watchdog must be able to hold TIMEOUT itself on the expiry edge.
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Op vectors are indexed 0 = hash, 1 = encrypt, 2 = decrypt (also the priority order).
  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0][10:0]   slot_q, slot_d;
  logic [2:0]         cur_oh_q;
  logic [10:0]        eng_off_q;
  logic [WDW-1:0]     wd_q;
  logic [2:0]         start_q;
  logic [2:0]         done_q;
  logic               abort_q;
  logic               wbhalt_q;
  logic               ovf_q;

  logic [2:0]         req_vec;
  logic [2:0]         fin_vec;
  logic               deq;
  logic [1:0]         sel_idx;
  logic [2:0]         deq_vec;
  logic               drop;
  logic               fin_hit;
  logic               wd_expire;

  assign req_vec   = {D_int, E_int, H_int};
  assign fin_vec   = {D_fin, E_fin, H_fin};
  assign fin_hit   = |(fin_vec & cur_oh_q);
  assign wd_expire = (wd_q == WD_LAST);

  // Pick the highest-priority queued op and update the pending set with this cycle's requests.
  always_comb begin
    sel_idx = 2'd2;
    if (pend_q[0]) begin
      sel_idx = 2'd0;
    end else if (pend_q[1]) begin
      sel_idx = 2'd1;
    end
    // A new op is only taken from IDLE or straight out of FINISH.
    deq     = ((state_q == IDLE) || (state_q == FINISH)) && (|pend_q);
    deq_vec = deq ? (3'b001 << sel_idx) : 3'b000;
    drop    = 1'b0;
    pend_d  = pend_q;
    slot_d  = slot_q;
    for (int k = 0; k < 3; k++) begin
      if (req_vec[k] && pend_q[k] && !deq_vec[k]) begin
        // Slot still occupied by an op that is not leaving: the new request is lost,
        // the queued offset is kept untouched.
        drop = 1'b1;
      end else if (req_vec[k]) begin
        pend_d[k] = 1'b1;
        slot_d[k] = offset;
      end else if (deq_vec[k]) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (deq) state_d = LAUNCH;
      LAUNCH:  state_d = BUSY;
      BUSY:    if (fin_hit || wd_expire) state_d = FINISH;
      FINISH:  state_d = deq ? LAUNCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dispatcher FSM, pending set, watchdog and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      slot_q    <= '0;
      cur_oh_q  <= '0;
      eng_off_q <= '0;
      wd_q      <= '0;
      start_q   <= '0;
      done_q    <= '0;
      abort_q   <= 1'b0;
      wbhalt_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      slot_q  <= slot_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (deq) begin
        cur_oh_q  <= deq_vec;
        eng_off_q <= slot_q[sel_idx];
      end
      // Launch pulse is the registered image of the LAUNCH cycle.
      start_q <= (state_q == LAUNCH) ? cur_oh_q : 3'b000;
      // Done/abort are raised on the edge that enters FINISH so they span the FINISH cycle;
      // a matching fin on the expiry cycle wins over the abort.
      done_q  <= ((state_q == BUSY) && (fin_hit || wd_expire)) ? cur_oh_q : 3'b000;
      abort_q <= (state_q == BUSY) && wd_expire && !fin_hit;
      // Watchdog only runs in BUSY, so it is already zero on BUSY entry.
      wd_q     <= (state_q == BUSY) ? (wd_q + WDW'(1)) : '0;
      wbhalt_q <= (state_d != IDLE) || (|pend_d);
    end
  end

  assign {D_start, E_start, H_start} = start_q;
  assign {D_done, E_done, H_done}    = done_q;
  assign eng_offset                  = eng_off_q;
  assign timeout_err                 = abort_q;
  assign wbhalt                      = wbhalt_q;
  assign ovf_err                     = ovf_q;

endmodule

// File: tb/tb_accel_dispatch.sv
// tb_accel_dispatch: directed scenarios for accel_dispatch against a timestamp-based model of the dispatcher.
// Latency: the model predicts each output for the cycle after every rising edge.
// Backpressure: the bench plays the engines, answering *_start with *_fin after chosen delays.
module tb_accel_dispatch;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  fin;
  logic [10:0] offset;
  logic        H_start, E_start, D_start;
  logic        H_done, E_done, D_done;
  logic [10:0] eng_offset;
  logic        wbhalt, timeout_err, ovf_err;

  accel_dispatch #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .H_int       (req[0]),
    .E_int       (req[1]),
    .D_int       (req[2]),
    .offset      (offset),
    .H_fin       (fin[0]),
    .E_fin       (fin[1]),
    .D_fin       (fin[2]),
    .H_start     (H_start),
    .E_start     (E_start),
    .D_start     (D_start),
    .eng_offset  (eng_offset),
    .H_done      (H_done),
    .E_done      (E_done),
    .D_done      (D_done),
    .wbhalt      (wbhalt),
    .timeout_err (timeout_err),
    .ovf_err     (ovf_err)
  );

  logic [2:0]  st_vec, dn_vec;
  logic [19:0] dut_vec, exp_vec;
  assign st_vec  = {D_start, E_start, H_start};
  assign dn_vec  = {D_done, E_done, H_done};
  assign dut_vec = {st_vec, dn_vec, wbhalt, timeout_err, ovf_err, eng_offset};

  // Model: queued ops plus the age (in edges) of the op that owns the engine.
  logic [2:0]  m_pend, m_start, m_done;
  logic [10:0] m_poff [3];
  logic [10:0] m_eoff;
  logic        m_act, m_tmo, m_ovf, m_halt;
  int          m_op, m_age, m_edge, m_free_at;
  assign exp_vec = {m_start, m_done, m_halt, m_tmo, m_ovf, m_eoff};

  int checks;
  int errors;
  int done_cnt [3];
  int start_log [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_start = '0; m_done = '0; m_eoff = '0;
    for (int k = 0; k < 3; k++) m_poff[k] = '0;
    m_act = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0; m_halt = 1'b0;
    m_op = 0; m_age = 0; m_edge = 0; m_free_at = 0;
  endtask

  // One rising edge: age the running op, or hand the engine to the best queued op,
  // then absorb this edge's requests.
  task automatic model_step();
    logic fin_now;
    int   pick;
    m_edge++;
    m_start = '0; m_done = '0; m_tmo = 1'b0; fin_now = 1'b0;
    if (m_act) begin
      m_age++;
      if (m_age == 1) begin
        m_start[m_op] = 1'b1;
      end else if (fin[m_op] || m_age == TO + 1) begin
        m_done[m_op] = 1'b1;
        m_tmo        = !fin[m_op];
        m_act        = 1'b0;
        fin_now      = 1'b1;
        m_free_at    = m_edge + 1;
      end
    end else if (m_pend != 3'b000 && m_edge >= m_free_at) begin
      pick = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
      m_pend[pick] = 1'b0;
      m_op   = pick;
      m_eoff = m_poff[pick];
      m_act  = 1'b1;
      m_age  = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (req[k]) begin
        if (m_pend[k]) m_ovf = 1'b1;
        else begin
          m_pend[k] = 1'b1;
          m_poff[k] = offset;
        end
      end
    end
    m_halt = m_act || fin_now || (m_pend != 3'b000);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input int k, input logic [10:0] off);
    req[k] = 1'b1;
    offset = off;
    tick();
    req = '0;
  endtask

  task automatic wait_start(input int k, input logic [10:0] off);
    int n = 0;
    while (!st_vec[k] && n < 30) begin
      tick();
      n++;
    end
    check("start_seen", 32'(st_vec[k]), 32'd1);
    check("start_offset", 32'(eng_offset), 32'(off));
  endtask

  task automatic finish_op(input int k, input int lat);
    repeat (lat) tick();
    fin[k] = 1'b1;
    tick();
    fin[k] = 1'b0;
    check("done_pulse", 32'(dn_vec[k]), 32'd1);
    check("done_no_timeout", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL sim_time_limit reached without finishing");
    $fatal(1);
  end

  initial begin
    int base;
    int sl;
    checks = 0; errors = 0;
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    rst_n = 1'b0; req = '0; fin = '0; offset = '0;
    model_reset();

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
      end
      forever begin
        @(negedge clk);
        check("cycle_compare", 32'(dut_vec), 32'(exp_vec));
      end
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (st_vec[k]) start_log.push_back(k);
          if (dn_vec[k]) done_cnt[k]++;
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    check("reset_outputs", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single encrypt op, engine answers 5 cycles after start
    launch(1, 11'h155);
    check("halt_rise", 32'(wbhalt), 32'd1);
    check("start_early0", 32'(E_start), 32'd0);
    tick();
    check("start_early1", 32'(E_start), 32'd0);
    tick();
    check("start_latency", 32'(E_start), 32'd1);
    check("start_off_155", 32'(eng_offset), 32'h155);
    repeat (5) tick();
    fin[1] = 1'b1;
    tick();
    fin[1] = 1'b0;
    check("e_done", 32'(E_done), 32'd1);
    tick();
    check("e_done_once", 32'(E_done), 32'd0);
    check("halt_fall", 32'(wbhalt), 32'd0);

    // Three simultaneous requests run H, E, D
    base = done_cnt[0] + done_cnt[1] + done_cnt[2];
    sl = start_log.size();
    req = 3'b111;
    offset = 11'h010;
    tick();
    req = '0;
    wait_start(0, 11'h010); finish_op(0, 2);
    wait_start(1, 11'h010); finish_op(1, 3);
    wait_start(2, 11'h010); finish_op(2, 1);
    tick();
    check("three_dones", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] - base), 32'd3);
    check("three_starts", 32'(start_log.size() - sl), 32'd3);
    if (start_log.size() >= sl + 3) begin
      check("order_h", 32'(start_log[sl]), 32'd0);
      check("order_e", 32'(start_log[sl + 1]), 32'd1);
      check("order_d", 32'(start_log[sl + 2]), 32'd2);
    end

    // Decrypt overflow: one queued behind the running op, the next dropped
    base = done_cnt[2];
    launch(2, 11'h0A1);
    wait_start(2, 11'h0A1);
    launch(2, 11'h0B2);
    launch(2, 11'h0C3);
    check("ovf_set", 32'(ovf_err), 32'd1);
    finish_op(2, 1);
    wait_start(2, 11'h0B2);
    finish_op(2, 2);
    repeat (3) tick();
    check("two_d_dones", 32'(done_cnt[2] - base), 32'd2);
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Hash op that never finishes: aborted TO cycles after BUSY entry
    launch(0, 11'h3FF);
    wait_start(0, 11'h3FF);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("abort_not_yet", 32'(H_done), 32'd0);
    end
    tick();
    check("abort_done", 32'(H_done), 32'd1);
    check("abort_err", 32'(timeout_err), 32'd1);
    repeat (2) tick();

    // Fin on the expiry cycle is a normal completion
    launch(0, 11'h001);
    wait_start(0, 11'h001);
    repeat (TO - 1) tick();
    fin[0] = 1'b1;
    tick();
    fin[0] = 1'b0;
    check("edge_fin_done", 32'(H_done), 32'd1);
    check("edge_fin_no_err", 32'(timeout_err), 32'd0);
    repeat (2) tick();

    // Foreign fin is ignored
    launch(0, 11'h2AA);
    wait_start(0, 11'h2AA);
    repeat (2) tick();
    fin[1] = 1'b1;
    tick();
    fin[1] = 1'b0;
    check("foreign_fin_h", 32'(H_done), 32'd0);
    check("foreign_fin_e", 32'(E_done), 32'd0);
    finish_op(0, 1);
    repeat (2) tick();

    // Reset during BUSY, stale fin afterwards
    base = done_cnt[1];
    launch(1, 11'h0E0);
    wait_start(1, 11'h0E0);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fin[1] = 1'b1;
    tick();
    fin[1] = 1'b0;
    repeat (4) tick();
    check("no_stale_done", 32'(done_cnt[1] - base), 32'd0);
    check("post_reset_outputs", 32'(dut_vec), 32'd0);

    // Capture on first edge after reset release; re-request on the dequeue edge is kept
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req[0] = 1'b1;
    offset = 11'h111;
    tick();
    check("first_capture", 32'(wbhalt), 32'd1);
    offset = 11'h222;
    tick();
    req = '0;
    wait_start(0, 11'h111);
    finish_op(0, 1);
    wait_start(0, 11'h222);
    finish_op(0, 1);
    tick();
    check("no_drop_on_dequeue", 32'(ovf_err), 32'd0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
